// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner: FSM state encoding,
// matrix geometry, idle/reset line patterns and two small helpers that work
// on active-low line vectors.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;  // {row_idx[1:0], col_idx[1:0]}

  // All columns pulled up: no key seen on the driven row.
  localparam logic [NUM_COLS-1:0] COL_IDLE  = 4'hF;
  // Row 0 driven low first after reset.
  localparam logic [NUM_ROWS-1:0] ROW_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  // Index of the lowest 0 bit of an active-low vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // True when exactly one line of an active-low vector is asserted.
  function automatic logic one_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Bundles the keypad matrix lines and the key-event outputs.
//   col       : keypad columns, active-low, asynchronous to clk
//   row       : row drive, one-hot active-low
//   key_code  : last accepted key {row_idx, col_idx}
//   key_valid : one-cycle strobe on an accepted press
//   key_held  : high from accepted press until debounced release
//   dbg_state : scanner FSM state, for observation only
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_COLS-1:0] col;
  logic [NUM_ROWS-1:0] row;
  logic [CODE_W-1:0]   key_code;
  // Handshake: key_valid is a single-cycle strobe with no ready/back-pressure.
  // The consumer must take the event in the cycle key_valid is high; key_code
  // is already stable in that cycle and stays so until the next accepted press.
  logic                key_valid;
  logic                key_held;
  kp_state_e           dbg_state;

  modport master (
    input  col,
    output row, key_code, key_valid, key_held, dbg_state
  );

  modport slave (
    output col,
    input  row, key_code, key_valid, key_held, dbg_state
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a bus of independent asynchronous lines.
// Flops reset to all ones (idle level of pulled-up active-low inputs).
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronised output, two clk cycles behind d_i
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one row at a time and reports a
// debounced key code with a one-cycle valid strobe and a held level.
//   clk, rst_n : clock, asynchronous active-low reset
//   kp         : keypad_scanner_if.master (col in; row, key_code, key_valid,
//                key_held, dbg_state out)
// Parameters:
//   SCAN_DIV       : clock cycles per row dwell (>= 2)
//   DEBOUNCE_SCANS : consecutive matching samples for press/release (>= 1)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  logic [NUM_COLS-1:0] col_s;

  logic [DIV_W-1:0]    div_q,      div_d;
  kp_state_e           state_q,    state_d;
  logic [NUM_ROWS-1:0] row_q,      row_d;
  logic [1:0]          row_idx_q,  row_idx_d;
  logic [1:0]          col_idx_q,  col_idx_d;
  logic [NUM_COLS-1:0] pat_q,      pat_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q,  key_held_d;

  logic                sample_c;
  logic                rotate_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  sync_2ff #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (kp.col),
    .q_o   (col_s)
  );

  // Row dwell divider; the last cycle of each dwell is the sample point so
  // the column lines have had the whole dwell to settle.
  always_comb begin
    sample_c = (div_q == DIV_LAST);
    div_d    = sample_c ? '0 : div_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    rotate_c    = 1'b0;
    cnt_inc_c   = cnt_q + CNT_ONE;

    if (sample_c) begin
      unique case (state_q)
        SCAN: begin
          // Only a single low column is a usable press; idle and
          // multi-key/ghost patterns just move on to the next row.
          if (one_low(col_s)) begin
            row_idx_d = low_index(row_q);
            col_idx_d = low_index(col_s);
            pat_d     = col_s;
            cnt_d     = CNT_ONE;
            if (CNT_ONE == CNT_TARGET) begin
              // Single-sample debounce: accept at the detecting sample.
              state_d     = HELD;
              key_code_d  = {low_index(row_q), low_index(col_s)};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            rotate_c = 1'b1;
          end
        end

        DEBOUNCE: begin
          if (col_s == pat_q) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_TARGET) begin
              state_d     = HELD;
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end else begin
            state_d  = SCAN;
            rotate_c = 1'b1;
          end
        end

        HELD: begin
          // Row stays frozen here, so keys on other rows are never seen.
          if (col_s == COL_IDLE) begin
            cnt_d = CNT_ONE;
            if (CNT_ONE == CNT_TARGET) begin
              state_d    = SCAN;
              key_held_d = 1'b0;
              rotate_c   = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end
        end

        RELEASE: begin
          if (col_s == COL_IDLE) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_TARGET) begin
              state_d    = SCAN;
              key_held_d = 1'b0;
              rotate_c   = 1'b1;
            end
          end else begin
            // Original key back or some other pattern: still held, and no
            // new key_valid is generated.
            state_d = HELD;
          end
        end

        default: begin
          state_d = SCAN;
        end
      endcase
    end

    // 1110 -> 1101 -> 1011 -> 0111 -> 1110
    if (rotate_c) begin
      row_d = {row_q[NUM_ROWS-2:0], row_q[NUM_ROWS-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      state_q     <= SCAN;
      row_q       <= ROW_RESET;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      pat_q       <= COL_IDLE;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      row_q       <= row_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.row       = row_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_SCANS = 3.
// A small keypad model pulls a column low when a pressed key sits on the
// currently driven row. Sample points fall on every 4th rising edge after
// reset release; stimulus changes right after a sample edge so that it is
// seen at the next one.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  // keys[r*4+c] = 1 means key (row r, col c) is pressed.
  logic [15:0] keys = '0;

  always_comb begin
    kp.col = COL_IDLE;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kp.row[r]) kp.col[c] = 1'b0;
      end
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  // Advance to just after the next sample edge.
  task automatic sample_edge();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % 4 != 0);
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (kp.key_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keys = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (kp.row !== 4'b1110) begin bad++; $display("FAIL rst_row got=%b exp=%b", kp.row, 4'b1110); end
    total++; if (kp.key_code !== 4'h0) begin bad++; $display("FAIL rst_code got=%h exp=%h", kp.key_code, 4'h0); end
    total++; if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", kp.key_valid); end
    total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL rst_held got=%b exp=0", kp.key_held); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (kp.row !== 4'b1110) begin bad++; $display("FAIL row0_dwell got=%b exp=%b", kp.row, 4'b1110); end
    sample_edge();
    total++; if (kp.row !== 4'b1101) begin bad++; $display("FAIL rot_row1 got=%b exp=%b", kp.row, 4'b1101); end
    sample_edge();
    total++; if (kp.row !== 4'b1011) begin bad++; $display("FAIL rot_row2 got=%b exp=%b", kp.row, 4'b1011); end
    sample_edge();
    total++; if (kp.row !== 4'b0111) begin bad++; $display("FAIL rot_row3 got=%b exp=%b", kp.row, 4'b0111); end
    sample_edge();
    total++; if (kp.row !== 4'b1110) begin bad++; $display("FAIL rot_wrap got=%b exp=%b", kp.row, 4'b1110); end
  endtask

  task automatic test_clean_press();
    int base;
    bit seen;
    base = valid_cnt;
    keys = '0;
    keys[9] = 1'b1;  // row 2, col 1
    wait_valid(64, seen);
    total++; if (!seen) begin bad++; $display("FAIL press_timeout got=none exp=key_valid"); end
    total++; if (kp.key_code !== 4'h9) begin bad++; $display("FAIL press_code got=%h exp=%h", kp.key_code, 4'h9); end
    total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL press_held got=%b exp=1", kp.key_held); end
    total++; if (kp.row !== 4'b1011) begin bad++; $display("FAIL press_row got=%b exp=%b", kp.row, 4'b1011); end
    @(posedge clk);
    #1;
    total++; if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL valid_width got=%b exp=0", kp.key_valid); end
    sample_edge();
    sample_edge();
    total++; if (kp.row !== 4'b1011) begin bad++; $display("FAIL row_frozen got=%b exp=%b", kp.row, 4'b1011); end
    keys = '0;
    sample_edge();
    sample_edge();
    total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL rel_early got=%b exp=1", kp.key_held); end
    sample_edge();
    total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL rel_held got=%b exp=0", kp.key_held); end
    total++; if (kp.row !== 4'b0111) begin bad++; $display("FAIL rel_resume got=%b exp=%b", kp.row, 4'b0111); end
    total++; if (valid_cnt - base !== 1) begin bad++; $display("FAIL press_pulses got=%0d exp=1", valid_cnt - base); end
  endtask

  task automatic test_bounce_press();
    int base;
    base = valid_cnt;
    keys = '0;
    keys[12] = 1'b1;  // row 3 (currently driven), col 0
    sample_edge();
    total++; if (kp.row !== 4'b0111) begin bad++; $display("FAIL bounce_capture got=%b exp=%b", kp.row, 4'b0111); end
    keys = '0;
    sample_edge();
    total++; if (kp.row !== 4'b1110) begin bad++; $display("FAIL bounce_resume got=%b exp=%b", kp.row, 4'b1110); end
    sample_edge();
    sample_edge();
    total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL bounce_held got=%b exp=0", kp.key_held); end
    total++; if (valid_cnt != base) begin bad++; $display("FAIL bounce_pulses got=%0d exp=0", valid_cnt - base); end
  endtask

  task automatic test_release_bounce();
    int base;
    bit seen;
    base = valid_cnt;
    keys = '0;
    keys[6] = 1'b1;  // row 1, col 2
    wait_valid(64, seen);
    total++; if (!seen) begin bad++; $display("FAIL rb_timeout got=none exp=key_valid"); end
    total++; if (kp.key_code !== 4'h6) begin bad++; $display("FAIL rb_code got=%h exp=%h", kp.key_code, 4'h6); end
    keys = '0;        // high
    sample_edge();
    total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL rb_held1 got=%b exp=1", kp.key_held); end
    keys[6] = 1'b1;   // low
    sample_edge();
    total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL rb_held2 got=%b exp=1", kp.key_held); end
    keys = '0;        // high, high, high
    sample_edge();
    total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL rb_held3 got=%b exp=1", kp.key_held); end
    sample_edge();
    total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL rb_held4 got=%b exp=1", kp.key_held); end
    sample_edge();
    total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL rb_drop got=%b exp=0", kp.key_held); end
    total++; if (valid_cnt - base !== 1) begin bad++; $display("FAIL rb_pulses got=%0d exp=1", valid_cnt - base); end
    total++; if (kp.key_code !== 4'h6) begin bad++; $display("FAIL rb_code_keep got=%h exp=%h", kp.key_code, 4'h6); end
  endtask

  task automatic test_multi_key();
    int base;
    logic [3:0] exp_row;
    base = valid_cnt;
    keys = '0;
    keys[0] = 1'b1;   // row 0 reads col = 1100
    keys[1] = 1'b1;
    exp_row = 4'b1011;
    total++; if (kp.row !== exp_row) begin bad++; $display("FAIL mk_start got=%b exp=%b", kp.row, exp_row); end
    for (int s = 0; s < 8; s++) begin
      exp_row = {exp_row[2:0], exp_row[3]};
      sample_edge();
      total++; if (kp.row !== exp_row) begin bad++; $display("FAIL mk_rot%0d got=%b exp=%b", s, kp.row, exp_row); end
    end
    total++; if (kp.key_code !== 4'h6) begin bad++; $display("FAIL mk_code got=%h exp=%h", kp.key_code, 4'h6); end
    total++; if (valid_cnt != base) begin bad++; $display("FAIL mk_pulses got=%0d exp=0", valid_cnt - base); end
    keys = '0;
  endtask

  task automatic test_second_key();
    int base;
    bit seen;
    base = valid_cnt;
    keys = '0;
    keys[5] = 1'b1;   // row 1, col 1
    wait_valid(64, seen);
    total++; if (!seen) begin bad++; $display("FAIL sk_timeout got=none exp=key_valid"); end
    total++; if (kp.key_code !== 4'h5) begin bad++; $display("FAIL sk_code got=%h exp=%h", kp.key_code, 4'h5); end
    keys[14] = 1'b1;  // row 3, col 2 added while held
    for (int s = 0; s < 4; s++) sample_edge();
    total++; if (valid_cnt - base !== 1) begin bad++; $display("FAIL sk_pulses got=%0d exp=1", valid_cnt - base); end
    total++; if (kp.key_code !== 4'h5) begin bad++; $display("FAIL sk_code_keep got=%h exp=%h", kp.key_code, 4'h5); end
    total++; if (kp.key_held !== 1'b1) begin bad++; $display("FAIL sk_held got=%b exp=1", kp.key_held); end
    total++; if (kp.row !== 4'b1101) begin bad++; $display("FAIL sk_row got=%b exp=%b", kp.row, 4'b1101); end
    keys = '0;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (kp.key_held === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL sk_release got=held exp=released"); end
    total++; if (kp.key_code !== 4'h5) begin bad++; $display("FAIL sk_code_after got=%h exp=%h", kp.key_code, 4'h5); end
  endtask

  task automatic test_reset_mid_debounce();
    int base;
    bit found;
    keys = '0;
    found = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sample_edge();
      if (kp.row === 4'b1110) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL rmd_align got=%b exp=%b", kp.row, 4'b1110); end
    base = valid_cnt;
    keys[3] = 1'b1;   // row 0, col 3
    sample_edge();
    sample_edge();
    rst_n = 1'b0;
    #1;
    total++; if (kp.row !== 4'b1110) begin bad++; $display("FAIL rmd_row got=%b exp=%b", kp.row, 4'b1110); end
    total++; if (kp.key_code !== 4'h0) begin bad++; $display("FAIL rmd_code got=%h exp=%h", kp.key_code, 4'h0); end
    total++; if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL rmd_valid got=%b exp=0", kp.key_valid); end
    total++; if (kp.key_held !== 1'b0) begin bad++; $display("FAIL rmd_held got=%b exp=0", kp.key_held); end
    keys = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sample_edge();
    total++; if (kp.row !== 4'b1101) begin bad++; $display("FAIL rmd_restart got=%b exp=%b", kp.row, 4'b1101); end
    total++; if (valid_cnt != base) begin bad++; $display("FAIL rmd_pulses got=%0d exp=0", valid_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_release_bounce();
    test_multi_key();
    test_second_key();
    test_reset_mid_debounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4×4 active-low matrix keypad and emits a debounced 4-bit key code with a one-cycle valid strobe.
- Input-side counterpart to the 7-segment output path: the display path drives digit/segment lines; this block drives row lines and reads column lines.
- Feeds key events into the counter/display datapath in place of the discrete debounced buttons.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per row dwell; must be ≥ 2.
- `DEBOUNCE_SCANS`, default 4: consecutive matching samples needed for press or release; must be ≥ 1.
- `clk`  input  1  system clock; the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `col`  input  4  keypad columns, active-low with external pull-ups, asynchronous to `clk`.
- `row`  output  4  row drive, one-hot active-low.
- `key_code`  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- `key_valid`  output  1  one-cycle pulse on an accepted press.
- `key_held`  output  1  high from an accepted press until its debounced release.

## Operation
- `col` passes through a 2-FF synchroniser; all logic uses the synchronised value `col_s`.
- Divider `div` counts 0..SCAN_DIV-1 and wraps.
  - Sample point: the cycle where `div == SCAN_DIV-1`.
  - Sampling late in the dwell lets the columns settle.
- Row rotation in SCAN only, at each sample point: 1110 → 1101 → 1011 → 0111 → 1110. Row index 0..3 follows the position of the 0 bit.
- Column index: the position of the single 0 bit in `col_s`.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN, at each sample point:
  - Exactly one `col_s` bit low: latch row index, column index and pattern; set match count to 1; go to DEBOUNCE. The row stays frozen.
  - `col_s` == 4'hF: no capture; rotate.
  - More than one bit low (multi-key or ghost): no capture; rotate.
- DEBOUNCE, at each sample point (row frozen):
  - `col_s` equals the latched pattern: increment the count. When the count reaches DEBOUNCE_SCANS, go to HELD.
  - Any other `col_s`: return to SCAN and resume rotation from the next row. No output.
  - With DEBOUNCE_SCANS = 1, the transition to HELD happens at the detecting sample.
- Entry to HELD:
  - `key_code` updates to {row_idx, col_idx}.
  - `key_valid` pulses for one cycle.
  - `key_held` rises.
- HELD, at each sample point: `col_s` == 4'hF → release count 1, go to RELEASE. Otherwise stay.
- RELEASE, at each sample point:
  - `col_s` == 4'hF: increment. At DEBOUNCE_SCANS, drop `key_held` and go to SCAN; rotation resumes from the next row.
  - Latched pattern reappears: back to HELD, no new `key_valid`.
  - Any other pattern: treated as still held; back to HELD.
- `key_code` holds its value until the next accepted press. A second key pressed while HELD is ignored.
- Reset values (asynchronous):
  - `row` = 4'b1110, `div` = 0, state SCAN, counts 0.
  - `key_code` = 4'h0, `key_valid` = 0, `key_held` = 0, synchroniser flops = 4'hF.
- Counters use the minimum width: `$clog2(SCAN_DIV)` for `div`, `$clog2(DEBOUNCE_SCANS+1)` for the match/release counts. No counter may overflow at the maximum legal parameter values.

## Timing
- All outputs are registered, with no combinational path from `col` to any output.
- `key_valid` and `key_held` assert in the cycle after the DEBOUNCE_SCANS-th matching sample point.
- Press latency from a stable `col` edge:
  - Minimum: 2 sync cycles + (DEBOUNCE_SCANS-1)·SCAN_DIV + 1 cycles.
  - Maximum: adds up to 4·SCAN_DIV of scan wait.
- Release: `key_held` falls in the cycle after the DEBOUNCE_SCANS-th all-high sample.
- `row` changes only in the cycle after a sample point.
- `rst_n` low mid-operation forces reset values immediately, with no `key_valid` emitted. On deassertion, scanning restarts at row 0.

## Structure
- Shared package `keypad_pkg` holds:
  - the state encoding (SCAN, DEBOUNCE, HELD, RELEASE);
  - `NUM_ROWS` = 4, `NUM_COLS` = 4;
  - the `COL_IDLE` = 4'hF constant.
- Sub-module `sync_2ff` (parameterised width, reset value 1s) is used for `col`.
- Divider, FSM and output registers live in `keypad_scanner`.

## Test plan
- All cases use SCAN_DIV = 4, DEBOUNCE_SCANS = 3.
- Reset: hold `rst_n` = 0, then release → `row` = 1110, `key_code` = 0, `key_valid` = 0, `key_held` = 0. `row` cycles 1110/1101/1011/0111 every 4 cycles.
- Clean press, row 2 / col 1: pull `col` to 1101 whenever `row` = 1011 → one `key_valid` pulse, `key_code` = 4'h9, `key_held` = 1, `row` frozen at 1011. Release → `key_held` = 0 after 3 high samples, then rotation resumes at 0111.
- Bounce: assert the key for 1 sample, then release → return to SCAN, no `key_valid`. A bounce during RELEASE (high, low, high, high, high) → `key_held` stays 1 until 3 consecutive high samples; exactly one `key_valid` total.
- Multi-key: `col` = 1100 on row 0 → no capture, rotation continues, `key_code` unchanged.
- Second key while held: hold 4'h5, then add a row-3 key → no new `key_valid`, `key_code` stays 4'h5.
- Reset mid-debounce: assert `rst_n` = 0 after 2 matching samples → outputs return to reset values at once, no `key_valid`, scan restarts at 1110.
